// File: rtl/tx_chan_sched_pkg.sv
// Shared types and default widths for the VSK/NSK TX channel scheduler.
// The packer-facing defaults (RAM_W, CNT_W, RANG_CNT_TX) are also used by mux_header.
package tx_sched_pkg;

    localparam int DEF_RAM_W       = 32;
    localparam int DEF_CNT_W       = 5;
    localparam int DEF_RANG_CNT_TX = 31;
    localparam int DEF_ADDR_W      = 10;
    localparam int DEF_BASE_N      = 512;
    localparam int DEF_GAP_CYC     = 4;

    typedef enum logic [1:0] {IDLE, GRANT, RUN, GAP} sched_state_t;
    typedef enum logic {CH_V, CH_N} chan_t;

endpackage

// File: rtl/tx_chan_sched_if.sv
// Request, packer and BRAM-write signals of tx_chan_sched bundled as one interface.
interface tx_chan_sched_if #(
    parameter int RAM_W  = tx_sched_pkg::DEF_RAM_W,
    parameter int CNT_W  = tx_sched_pkg::DEF_CNT_W,
    parameter int ADDR_W = tx_sched_pkg::DEF_ADDR_W
);
    import tx_sched_pkg::*;

    logic              req_v;
    logic              req_n;
    logic [ADDR_W-1:0] frame_len;
    logic              abort;
    logic [CNT_W-1:0]  cnt_data;
    logic [RAM_W-1:0]  word_in;
    logic              mvsk_on;
    logic              mnsk_on;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [RAM_W-1:0]  ram_wdata;
    logic              busy;
    logic              done_v;
    logic              done_n;
    logic              err;

    modport slave (
        input  req_v, req_n, frame_len, abort, cnt_data, word_in,
        output mvsk_on, mnsk_on, ram_we, ram_addr, ram_wdata, busy, done_v, done_n, err
    );

    modport master (
        output req_v, req_n, frame_len, abort, cnt_data, word_in,
        input  mvsk_on, mnsk_on, ram_we, ram_addr, ram_wdata, busy, done_v, done_n, err
    );

endinterface

// File: rtl/tx_chan_sched_word_detect.sv
// Detects packer word completion (bit counter wrapping to 0 while enabled)
// and issues the registered BRAM write one cycle later.
module tx_word_detect #(
    parameter int RAM_W       = tx_sched_pkg::DEF_RAM_W,
    parameter int CNT_W       = tx_sched_pkg::DEF_CNT_W,
    parameter int RANG_CNT_TX = tx_sched_pkg::DEF_RANG_CNT_TX,
    parameter int ADDR_W      = tx_sched_pkg::DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              on_act,
    input  logic [CNT_W-1:0]  cnt_data,
    input  logic [RAM_W-1:0]  word_in,
    input  logic [ADDR_W-1:0] addr,
    output logic              wrap,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [RAM_W-1:0]  wdata
);
    import tx_sched_pkg::*;

    logic [CNT_W-1:0] cnt_prev;

    assign wrap = on_act && (cnt_prev == CNT_W'(RANG_CNT_TX)) && (cnt_data == '0);

    always_ff @(posedge clk) begin
        if (nrst) begin
            cnt_prev <= '0;
            we       <= 1'b0;
            waddr    <= '0;
            wdata    <= '0;
        end else begin
            cnt_prev <= cnt_data;
            we       <= wrap;
            if (wrap) begin
                waddr <= addr;
                wdata <= word_in;
            end
        end
    end

endmodule

// File: rtl/tx_chan_sched.sv
// VSK/NSK TX packer scheduler: grants one channel per frame, writes finished words to BRAM.
// Define TX_SCHED_RR_EN for round-robin tie breaking; otherwise VSK wins every tie.
module tx_chan_sched #(
    parameter int RAM_W       = tx_sched_pkg::DEF_RAM_W,
    parameter int CNT_W       = tx_sched_pkg::DEF_CNT_W,
    parameter int RANG_CNT_TX = tx_sched_pkg::DEF_RANG_CNT_TX,
    parameter int ADDR_W      = tx_sched_pkg::DEF_ADDR_W,
    parameter int BASE_N      = tx_sched_pkg::DEF_BASE_N,
    parameter int GAP_CYC     = tx_sched_pkg::DEF_GAP_CYC
) (
    input  logic            clk,
    input  logic            nrst,
    tx_chan_sched_if.slave  bus
);
    import tx_sched_pkg::*;

    localparam int GAP_W = $clog2(GAP_CYC + 1);

    sched_state_t      state, nxt;
    chan_t             chan, pick;
    logic [ADDR_W-1:0] len_m1, base, word_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic              on_act, wrap, last_word, frame_end;

    assign on_act    = bus.mvsk_on | bus.mnsk_on;
    assign last_word = wrap && (word_cnt == len_m1);
    assign frame_end = (state == RUN) && (nxt == GAP);

`ifdef TX_SCHED_RR_EN
    chan_t last_ch;

    always_comb begin
        pick = CH_V;
        if (bus.req_v && bus.req_n)
            pick = (last_ch == CH_N) ? CH_V : CH_N;
        else if (bus.req_n)
            pick = CH_N;
    end

    // Reset value NSK makes the first tie go to VSK.
    always_ff @(posedge clk) begin
        if (nrst)
            last_ch <= CH_N;
        else if (state == IDLE && nxt == GRANT)
            last_ch <= pick;
    end
`else
    assign pick = bus.req_v ? CH_V : CH_N;
`endif

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (bus.req_v || bus.req_n) nxt = GRANT;
            GRANT:   nxt = RUN;
            RUN:     if (bus.abort || last_word) nxt = GAP;
            GAP:     if (gap_cnt == GAP_W'(GAP_CYC - 1)) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            state       <= IDLE;
            chan        <= CH_V;
            len_m1      <= '0;
            base        <= '0;
            word_cnt    <= '0;
            gap_cnt     <= '0;
            bus.mvsk_on <= 1'b0;
            bus.mnsk_on <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done_v  <= 1'b0;
            bus.done_n  <= 1'b0;
            bus.err     <= 1'b0;
        end else begin
            state <= nxt;
            if (state == IDLE && nxt == GRANT)
                chan <= pick;
            if (state == GRANT) begin
                len_m1   <= (bus.frame_len == '0) ? '0 : bus.frame_len - ADDR_W'(1);
                base     <= (chan == CH_N) ? ADDR_W'(BASE_N) : '0;
                word_cnt <= '0;
            end else if (wrap) begin
                word_cnt <= word_cnt + ADDR_W'(1);
            end
            gap_cnt     <= (state == GAP) ? gap_cnt + GAP_W'(1) : '0;
            bus.mvsk_on <= (nxt == RUN) && (chan == CH_V);
            bus.mnsk_on <= (nxt == RUN) && (chan == CH_N);
            bus.busy    <= (nxt != IDLE);
            bus.done_v  <= frame_end && (chan == CH_V);
            bus.done_n  <= frame_end && (chan == CH_N);
            // Abort coinciding with the final wrap still flags the frame.
            bus.err     <= frame_end && bus.abort;
        end
    end

    // Address arithmetic wraps naturally at 2^ADDR_W.
    tx_word_detect #(
        .RAM_W       (RAM_W),
        .CNT_W       (CNT_W),
        .RANG_CNT_TX (RANG_CNT_TX),
        .ADDR_W      (ADDR_W)
    ) u_detect (
        .clk      (clk),
        .nrst     (nrst),
        .on_act   (on_act),
        .cnt_data (bus.cnt_data),
        .word_in  (bus.word_in),
        .addr     (base + word_cnt),
        .wrap     (wrap),
        .we       (bus.ram_we),
        .waddr    (bus.ram_addr),
        .wdata    (bus.ram_wdata)
    );

endmodule

// File: tb/tb_tx_chan_sched.sv
// Randomized self-checking bench for tx_chan_sched; expectations come from frame-level
// rules (words per frame, region base, abort point) rather than the RTL's state machine.
module tb_tx_chan_sched;

`ifdef TX_SCHED_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam int GAP = 4;

    logic clk = 1'b0;
    logic nrst;
    int   vec = 0;
    int   mis = 0;
    bit   last_n;

    tx_chan_sched_if bus ();

    tx_chan_sched dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        bus.req_v     = 1'b0;
        bus.req_n     = 1'b0;
        bus.frame_len = '0;
        bus.abort     = 1'b0;
        bus.cnt_data  = '0;
        bus.word_in   = '0;
    endtask

    // One frame from an IDLE cycle through the end of the gap.
    // ka: bit cycle of an abort pulse (-1 = none); keep: leave requests high afterwards.
    task automatic do_frame(input bit rv, input bit rn, input int len, input int ka,
                            input bit keep, input bit gnt_abort);
        bit          exp_n, err_exp, we_exp;
        int          L, nw, kend;
        logic [9:0]  base, ea;
        logic [31:0] w[$];
        exp_n   = (rv && rn) ? (RR ? !last_n : 1'b0) : rn;
        last_n  = exp_n;
        L       = (len == 0) ? 1 : len;
        for (int i = 0; i <= L; i++) w.push_back($urandom);
        nw      = (ka < 0) ? L : ((ka / 32 < L) ? ka / 32 : L);
        kend    = (ka < 0 || ka > 32 * L) ? 32 * L : ka;
        err_exp = (ka >= 0 && ka <= 32 * L);
        base    = exp_n ? 10'd512 : 10'd0;

        bus.req_v = rv; bus.req_n = rn; bus.frame_len = 10'(len);
        tick;
        vec++;
        if ({bus.busy, bus.mvsk_on, bus.mnsk_on} !== 3'b100) begin
            mis++; $display("FAIL grant_cycle: busy/on got %b want 100", {bus.busy, bus.mvsk_on, bus.mnsk_on});
        end
        bus.abort = gnt_abort;
        tick;
        bus.abort = 1'b0;
        vec++;
        if ({bus.mvsk_on, bus.mnsk_on} !== {!exp_n, exp_n}) begin
            mis++; $display("FAIL chan_on: got %b want %b", {bus.mvsk_on, bus.mnsk_on}, {!exp_n, exp_n});
        end
        if (!keep) begin bus.req_v = 1'b0; bus.req_n = 1'b0; end

        for (int k = 0; k <= kend; k++) begin
            bus.cnt_data = 5'(k % 32);
            bus.word_in  = w[(k == 0) ? 0 : (k - 1) / 32];
            bus.abort    = (k == ka);
            tick;
            we_exp = (k > 0 && k % 32 == 0 && k / 32 <= nw);
            vec++;
            if (bus.ram_we !== we_exp) begin
                mis++; $display("FAIL ram_we bit %0d: got %b want %b", k, bus.ram_we, we_exp);
            end
            if (we_exp) begin
                ea = base + 10'(k / 32 - 1);
                vec++;
                if ({bus.ram_addr, bus.ram_wdata} !== {ea, w[k / 32 - 1]}) begin
                    mis++; $display("FAIL ram_write bit %0d: got %0d/%h want %0d/%h",
                                    k, bus.ram_addr, bus.ram_wdata, ea, w[k / 32 - 1]);
                end
            end
            if (k < kend) begin
                vec++;
                if ({bus.mvsk_on, bus.mnsk_on} !== {!exp_n, exp_n}) begin
                    mis++; $display("FAIL on_hold bit %0d: got %b", k, {bus.mvsk_on, bus.mnsk_on});
                end
            end
        end
        bus.abort = 1'b0;
        vec++;
        if ({bus.mvsk_on, bus.mnsk_on, bus.busy, bus.done_v, bus.done_n, bus.err} !==
            {2'b00, 1'b1, !exp_n, exp_n, err_exp}) begin
            mis++; $display("FAIL frame_end: on/busy/dv/dn/err got %b want %b",
                {bus.mvsk_on, bus.mnsk_on, bus.busy, bus.done_v, bus.done_n, bus.err},
                {2'b00, 1'b1, !exp_n, exp_n, err_exp});
        end

        // Gap: extra packer bits and a stray abort must have no effect.
        for (int g = 1; g <= GAP; g++) begin
            bus.cnt_data = (g <= 2) ? 5'((kend + g) % 32) : 5'd0;
            bus.abort    = (g == 2);
            tick;
            vec++;
            if ({bus.busy, bus.done_v, bus.done_n, bus.ram_we, bus.mvsk_on, bus.mnsk_on} !==
                {(g < GAP), 5'b0}) begin
                mis++; $display("FAIL gap %0d: busy/dv/dn/we/on got %b want %b", g,
                    {bus.busy, bus.done_v, bus.done_n, bus.ram_we, bus.mvsk_on, bus.mnsk_on},
                    {(g < GAP), 5'b0});
            end
        end
        bus.abort = 1'b0;
    endtask

    task automatic pulse_reset;
        nrst = 1'b1;
        tick;
        vec++;
        if ({bus.mvsk_on, bus.mnsk_on, bus.ram_we, bus.ram_addr, bus.ram_wdata,
             bus.busy, bus.done_v, bus.done_n, bus.err} !== '0) begin
            mis++; $display("FAIL reset_outputs: got on=%b%b we=%b addr=%0d busy=%b done=%b%b err=%b",
                bus.mvsk_on, bus.mnsk_on, bus.ram_we, bus.ram_addr, bus.busy,
                bus.done_v, bus.done_n, bus.err);
        end
        nrst   = 1'b0;
        last_n = 1'b1;
        tick;
    endtask

    task automatic test_reset;
        clear_inputs;
        bus.cnt_data = 5'(31);
        bus.word_in  = $urandom;
        nrst = 1'b1;
        tick;
        bus.cnt_data = '0;
        pulse_reset;
        vec++;
        if (bus.busy !== 1'b0) begin
            mis++; $display("FAIL idle_after_reset: busy got %b want 0", bus.busy);
        end
    endtask

    task automatic test_basic;
        do_frame(1'b1, 1'b0, 3, -1, 1'b0, 1'b0);
        do_frame(1'b0, 1'b1, 2, -1, 1'b0, 1'b0);
        do_frame(1'b1, 1'b0, 0, -1, 1'b0, 1'b1);
    endtask

    task automatic test_abort;
        do_frame(1'b1, 1'b0, 4, 32 + 10, 1'b0, 1'b0);
        do_frame(1'b0, 1'b1, 4, 64, 1'b0, 1'b0);
        do_frame(1'b1, 1'b0, 2, 64, 1'b0, 1'b0);
        do_frame(1'b0, 1'b1, 3, 5, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        pulse_reset;
        do_frame(1'b1, 1'b1, 1, -1, 1'b1, 1'b0);
        do_frame(1'b1, 1'b1, 1, -1, 1'b1, 1'b0);
        do_frame(1'b1, 1'b1, 2, -1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_midframe;
        bus.req_v = 1'b1; bus.frame_len = 10'd3;
        tick; tick;
        for (int k = 0; k < 45; k++) begin
            bus.cnt_data = 5'(k % 32);
            bus.word_in  = $urandom;
            tick;
        end
        bus.req_v = 1'b0;
        bus.cnt_data = '0;
        pulse_reset;
        for (int i = 0; i < 6; i++) begin
            tick;
            vec++;
            if ({bus.busy, bus.done_v, bus.done_n, bus.ram_we, bus.mvsk_on, bus.mnsk_on} !== 6'b0) begin
                mis++; $display("FAIL post_reset_idle %0d: got %b want 000000", i,
                    {bus.busy, bus.done_v, bus.done_n, bus.ram_we, bus.mvsk_on, bus.mnsk_on});
            end
        end
        do_frame(1'b1, 1'b0, 2, -1, 1'b0, 1'b0);
    endtask

    task automatic test_random;
        bit rv, rn;
        int len, L, ka;
        for (int f = 0; f < 14; f++) begin
            rv  = $urandom_range(0, 1);
            rn  = rv ? 1'($urandom_range(0, 1)) : 1'b1;
            len = $urandom_range(0, 4);
            L   = (len == 0) ? 1 : len;
            ka  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 32 * L) : -1;
            do_frame(rv, rn, len, ka, 1'b0, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_addr_wrap;
        do_frame(1'b0, 1'b1, 514, -1, 1'b0, 1'b0);
    endtask

    initial begin
        nrst   = 1'b1;
        last_n = 1'b1;
        clear_inputs;
        test_reset;
        test_basic;
        test_abort;
        test_back_to_back;
        test_reset_midframe;
        test_random;
        test_addr_wrap;
        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end

endmodule

// File: doc/tx_chan_sched.md
Name: tx_chan_sched

Overview:
- Scheduler/arbiter for the VSK/NSK serial-to-word TX packer.
- Grants the packer to one channel at a time by driving mvsk_on/mnsk_on.
- Detects each completed word from the packer's bit counter and writes it into the TX BRAM, into a per-channel address region.
- Ends a frame after the requested word count, then waits a guard gap before granting again.
- Sits between the channel request logic and the packer/BRAM TX port. All inputs are synchronous to clk; NSK-domain synchronisation happens upstream.

Parameters:
- RAM_W, 32, packer word width (MSB_RAM+1).
- CNT_W, 5, width of the packer bit counter.
- RANG_CNT_TX, 31, last bit index of a word; the packer wraps after it.
- ADDR_W, 10, BRAM word address width.
- BASE_N, 512, first BRAM address of the NSK region; the VSK region starts at 0.
- GAP_CYC, 4, idle cycles between frames (minimum 2).

Ports:
- clk  in  1  clock
- nrst  in  1  synchronous reset, active-high
- req_v  in  1  VSK frame request, level; sampled only in IDLE
- req_n  in  1  NSK frame request, level; sampled only in IDLE
- frame_len  in  ADDR_W  words per frame; captured at grant; 0 is treated as 1
- abort  in  1  terminate the current frame
- cnt_data  in  CNT_W  packer bit counter
- word_in  in  RAM_W  packer assembled word
- mvsk_on  out  1  packer enable, VSK
- mnsk_on  out  1  packer enable, NSK
- ram_we  out  1  BRAM write strobe
- ram_addr  out  ADDR_W  BRAM write address
- ram_wdata  out  RAM_W  BRAM write data
- busy  out  1  high in any state except IDLE
- done_v  out  1  one-cycle pulse, VSK frame finished
- done_n  out  1  one-cycle pulse, NSK frame finished
- err  out  1  qualifies a done pulse: frame was aborted

Behaviour:
- Reset (nrst=1): state IDLE; all outputs 0; word counter 0; last grant = NSK. The first tie therefore goes to VSK.
- Every output is registered.
- States:
  - IDLE: at least one request present -> GRANT.
  - GRANT: one cycle. Latch the channel, frame_len and base address (0 or BASE_N). Assert the selected *_on from the next cycle.
  - RUN: selected *_on held high.
  - GAP: both *_on low; count GAP_CYC cycles, then -> IDLE.
- Word detect: wrap = on_active AND cnt_prev==RANG_CNT_TX AND cnt_data==0. cnt_prev is cnt_data registered every cycle.
- Word write, on the cycle after wrap:
  - ram_we=1, ram_wdata = word_in sampled on the wrap cycle, ram_addr = base + word_cnt.
  - Then word_cnt increments.
  - Latency from wrap to ram_we: 1 cycle.
- Frame end: the wrap of word number frame_len -> *_on drops on the next cycle, together with ram_we -> GAP. done_x pulses on the first GAP cycle with err=0.
- Abort in RUN: *_on drops on the next cycle and any partial word is discarded -> GAP. done_x pulses with err=1.
- Abort and wrap in the same cycle: the word is still written; err=1.
- Abort outside RUN is ignored.
- Address wrap: base+word_cnt is taken modulo 2^ADDR_W. The frame is not truncated.
- Requests dropped before GRANT are not served. A request still high after GAP is served again; no request latching.
- Extra bit sampled by the packer between the final wrap and *_on falling: ignored; the packer counter clears itself.
- Reset mid-frame: immediate return to IDLE. No done pulse; ram_we=0 from the next cycle.

Optional Feature:
- Macro TX_SCHED_RR_EN.
- Defined: round-robin. On simultaneous req_v and req_n, grant the channel not granted last.
- Undefined: fixed priority, VSK always wins a tie; the last-grant register is not built.

Decomposition:
- Package tx_sched_pkg holds:
  - state enum sched_state_t {IDLE, GRANT, RUN, GAP};
  - channel enum chan_t {CH_V, CH_N};
  - the RANG_CNT_TX, RAM_W and CNT_W defaults, shared with mux_header.
- One sub-module, tx_word_detect: cnt_prev register, wrap detect, word capture, delayed write strobe.

Test Plan:
- req_v=1, frame_len=3; drive cnt_data through 0..31 three times -> mvsk_on high, ram_we at addr 0,1,2, done_v=1 with err=0, then 4 GAP cycles with busy=1.
- req_n=1, frame_len=2, word_in=32'hA5A5_0001 then 32'hA5A5_0002 -> writes at addr 512 and 513 with matching data; mnsk_on only.
- req_v=req_n=1 held through two frames -> with TX_SCHED_RR_EN: V then N; without it: V then V.
- abort pulse at cnt_data=10 of word 1, frame_len=4 -> one write at addr 0, *_on low next cycle, done_v=1 with err=1.
- abort on the same cycle as the second wrap -> writes at addr 0 and 1, done with err=1.
- nrst=1 during RUN -> all outputs 0 next cycle, no done pulse, state IDLE; a new req_v gives a fresh write at addr 0.
